// File: rtl/echo_msg_pkg.sv
// rtl/echo_msg_pkg.sv - shared types and header helpers for the echo indication serializer
package echo_msg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } echo_state_t;

    localparam int HDR_ID_W  = 16;
    localparam int HDR_LEN_W = 16;

    localparam logic [HDR_LEN_W-1:0] HDR_PAYLOAD_LEN = 16'd1;

    // Header layout: method id in [31:16], payload word count in [15:0]
    function automatic logic [HDR_ID_W+HDR_LEN_W-1:0] build_header(
        input logic [HDR_ID_W-1:0]  id,
        input logic [HDR_LEN_W-1:0] len
    );
        return {id, len};
    endfunction

endpackage

// File: rtl/echo_resp_fifo.sv
// rtl/echo_resp_fifo.sv - synchronous FIFO with wrap-bit pointers
module echo_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    input  logic             deq__ENA,
    output logic [WIDTH-1:0] first,
    output logic             full,
    output logic             empty,
    output logic             one_left
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign used     = wr_ptr - rd_ptr;
    assign one_left = (used == {{AW{1'b0}}, 1'b1});
    assign first    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq__ENA && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (deq__ENA && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq__ENA && !full)
            mem[wr_ptr[AW-1:0]] <= enq_v;
    end

endmodule

// File: rtl/echo_indication_serializer.sv
// rtl/echo_indication_serializer.sv - buffers echo indications and emits header/payload word pairs
module echo_indication_serializer
    import echo_msg_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] METHOD_ID = 16'h0001
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        echo__ENA,
    input  logic [31:0] echo_v,
    output logic        echo__RDY,
    output logic        pipe_enq__ENA,
    output logic [31:0] pipe_enq_v,
    input  logic        pipe_enq__RDY,
    output logic [31:0] msgCount,
    output logic        msgCount__RDY
);

    echo_state_t state;
    logic [31:0] msg_count_r;
    logic [31:0] fifo_first;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_one_left;
    logic        push;
    logic        pop;

    assign push          = echo__ENA && !fifo_full;
    assign pop           = (state == PAYLOAD) && pipe_enq__RDY;
    assign echo__RDY     = !fifo_full;
    assign msgCount      = msg_count_r;
    assign msgCount__RDY = 1'b1;

    echo_resp_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .CLK      (CLK),
        .nRST     (nRST),
        .enq__ENA (push),
        .enq_v    (echo_v),
        .deq__ENA (pop),
        .first    (fifo_first),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .one_left (fifo_one_left)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state         <= IDLE;
            pipe_enq__ENA <= 1'b0;
            pipe_enq_v    <= '0;
            msg_count_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state         <= HEADER;
                        pipe_enq__ENA <= 1'b1;
                        pipe_enq_v    <= build_header(METHOD_ID, HDR_PAYLOAD_LEN);
                    end
                end
                HEADER: begin
                    if (pipe_enq__RDY) begin
                        state      <= PAYLOAD;
                        pipe_enq_v <= fifo_first;
                    end
                end
                PAYLOAD: begin
                    if (pipe_enq__RDY) begin
                        msg_count_r <= msg_count_r + 32'd1;
                        // A word remains after this pop, or one arrives alongside it
                        if (!fifo_one_left || push) begin
                            state      <= HEADER;
                            pipe_enq_v <= build_header(METHOD_ID, HDR_PAYLOAD_LEN);
                        end else begin
                            state         <= IDLE;
                            pipe_enq__ENA <= 1'b0;
                            pipe_enq_v    <= '0;
                        end
                    end
                end
                default: begin
                    state         <= IDLE;
                    pipe_enq__ENA <= 1'b0;
                    pipe_enq_v    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_echo_indication_serializer.sv
// tb/tb_echo_indication_serializer.sv - directed self-checking bench for echo_indication_serializer
module tb_echo_indication_serializer;

    localparam logic [31:0] HDR = 32'h0001_0001;

    logic        CLK;
    logic        nRST;
    logic        echo_ena;
    logic [31:0] echo_v;
    logic        echo_rdy;
    logic        pipe_ena;
    logic [31:0] pipe_v;
    logic        pipe_rdy;
    logic [31:0] msg_count;
    logic        msg_count_rdy;

    int checks;
    int failures;

    logic [31:0] fill_words [5];

    echo_indication_serializer #(
        .DEPTH     (4),
        .METHOD_ID (16'h0001)
    ) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .echo__ENA     (echo_ena),
        .echo_v        (echo_v),
        .echo__RDY     (echo_rdy),
        .pipe_enq__ENA (pipe_ena),
        .pipe_enq_v    (pipe_v),
        .pipe_enq__RDY (pipe_rdy),
        .msgCount      (msg_count),
        .msgCount__RDY (msg_count_rdy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        fill_words[0] = 32'hA000_0000;
        fill_words[1] = 32'hA111_1111;
        fill_words[2] = 32'hA222_2222;
        fill_words[3] = 32'hA333_3333;
        fill_words[4] = 32'hA444_4444;
        echo_ena = 1'b0;
        echo_v   = '0;
        pipe_rdy = 1'b1;
        nRST     = 1'b1;
        #1 nRST  = 1'b0;
        step();
        step();
        chk("reset_ena", {31'd0, pipe_ena}, 32'd0);
        chk("reset_v", pipe_v, 32'd0);
        chk("reset_echo_rdy", {31'd0, echo_rdy}, 32'd1);
        chk("reset_count", msg_count, 32'd0);
        chk("count_rdy", {31'd0, msg_count_rdy}, 32'd1);
        nRST = 1'b1;
        step();

        // single indication
        echo_ena = 1'b1; echo_v = 32'hDEADBEEF;
        step();
        echo_ena = 1'b0;
        chk("single_idle_t", {31'd0, pipe_ena}, 32'd0);
        step();
        chk("single_hdr_ena", {31'd0, pipe_ena}, 32'd1);
        chk("single_hdr", pipe_v, HDR);
        step();
        chk("single_payload", pipe_v, 32'hDEADBEEF);
        step();
        chk("single_idle_ena", {31'd0, pipe_ena}, 32'd0);
        chk("single_idle_v", pipe_v, 32'd0);
        chk("single_count", msg_count, 32'd1);

        // backpressure held in HEADER
        pipe_rdy = 1'b0;
        echo_ena = 1'b1; echo_v = 32'h12345678;
        step();
        echo_ena = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hdr_ena", {31'd0, pipe_ena}, 32'd1);
            chk("bp_hdr", pipe_v, HDR);
            if (i < 4) step();
        end
        pipe_rdy = 1'b1;
        step();
        chk("bp_payload", pipe_v, 32'h12345678);
        step();
        chk("bp_idle", {31'd0, pipe_ena}, 32'd0);
        chk("bp_count", msg_count, 32'd2);

        // fill to full; fifth push must be ignored
        pipe_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fill_echo_rdy", {31'd0, echo_rdy}, (i < 4) ? 32'd1 : 32'd0);
            echo_ena = 1'b1; echo_v = fill_words[i];
            step();
        end
        echo_ena = 1'b0;
        chk("fill_full_rdy", {31'd0, echo_rdy}, 32'd0);
        chk("fill_hdr", pipe_v, HDR);
        pipe_rdy = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("drain_ena", {31'd0, pipe_ena}, 32'd1);
            chk("drain_word", pipe_v, (k % 2 == 0) ? fill_words[k/2] : HDR);
        end
        step();
        chk("drain_idle", {31'd0, pipe_ena}, 32'd0);
        chk("drain_count", msg_count, 32'd6);

        // push lands on the cycle the last word is popped
        echo_ena = 1'b1; echo_v = 32'hB000_000B;
        step();
        echo_ena = 1'b0;
        step();
        step();
        chk("sim_payload0", pipe_v, 32'hB000_000B);
        echo_ena = 1'b1; echo_v = 32'hB111_111B;
        step();
        echo_ena = 1'b0;
        chk("sim_hdr_ena", {31'd0, pipe_ena}, 32'd1);
        chk("sim_hdr", pipe_v, HDR);
        chk("sim_count7", msg_count, 32'd7);
        step();
        chk("sim_payload1", pipe_v, 32'hB111_111B);
        step();
        chk("sim_idle", {31'd0, pipe_ena}, 32'd0);
        chk("sim_count8", msg_count, 32'd8);

        // reset mid-message with a second word buffered
        echo_ena = 1'b1; echo_v = 32'hC000_000C;
        step();
        echo_v = 32'hC111_111C;
        step();
        echo_ena = 1'b0;
        step();
        chk("rst_pre_payload", pipe_v, 32'hC000_000C);
        nRST = 1'b0;
        #1;
        chk("rst_async_ena", {31'd0, pipe_ena}, 32'd0);
        chk("rst_async_v", pipe_v, 32'd0);
        chk("rst_async_count", msg_count, 32'd0);
        chk("rst_async_rdy", {31'd0, echo_rdy}, 32'd1);
        step();
        nRST = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_replay", {31'd0, pipe_ena}, 32'd0);
        end

        // counter wrap
        force dut.msg_count_r = 32'hFFFF_FFFF;
        #1;
        release dut.msg_count_r;
        #1;
        chk("wrap_preload", msg_count, 32'hFFFF_FFFF);
        step();
        echo_ena = 1'b1; echo_v = 32'hD000_000D;
        step();
        echo_ena = 1'b0;
        step();
        step();
        chk("wrap_payload", pipe_v, 32'hD000_000D);
        step();
        chk("wrap_count", msg_count, 32'd0);
        chk("wrap_idle", {31'd0, pipe_ena}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
